fetch_unit: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core.
- Produces the opcode consumed by the main control decoder: op_o = IF/ID instruction [31:26].
- Acts on that decoder's Branch and Jump outputs, returned from ID, to redirect the PC.
- Owns the PC, start sequencing, stall hold, taken-branch/jump flush and a redirect counter.

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_target_calc.sv | 29 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch constants and the fetch FSM state type.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_J     = 6'b000010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target computation from the IF/ID fields: branch and jump targets,
// the selected target, and whether the decoded control asks for a redirect.
module fetch_target_calc
    import mips_pkg::*;
(
    input  logic [25:0] ifid_index_i,
    input  logic [31:0] ifid_pc4_i,
    input  logic        ifid_valid_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        eq_i,
    output logic [31:0] btarget_o,
    output logic [31:0] jtarget_o,
    output logic [31:0] target_o,
    output logic        hit_o
);

    logic [31:0] offset;

    always_comb begin
        offset    = {{14{ifid_index_i[15]}}, ifid_index_i[15:0], 2'b00};
        btarget_o = ifid_pc4_i + offset;
        jtarget_o = {ifid_pc4_i[31:28], ifid_index_i, 2'b00};
        // Jump takes precedence when the decoder raises both.
        target_o  = jump_i ? jtarget_o : btarget_o;
        hit_o     = ifid_valid_i & (jump_i | (branch_i & eq_i));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, start/stall sequencing,
// one-bubble branch/jump redirect and a saturating redirect counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic             eq_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic [5:0]       op_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc4;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic [31:0] target;
    logic        hit;
    logic        take;

    fetch_target_calc u_target (
        .ifid_index_i (instr_q[25:0]),
        .ifid_pc4_i   (pc4_q),
        .ifid_valid_i (valid_q),
        .branch_i     (branch_i),
        .jump_i       (jump_i),
        .eq_i         (eq_i),
        .btarget_o    (btarget),
        .jtarget_o    (jtarget),
        .target_o     (target),
        .hit_o        (hit)
    );

    always_comb begin
        pc4     = pc_q + PC_STEP;
        take    = (state_q == RUN) & ~stall_i & hit;

        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // The edge that leaves IDLE already registers the fetch at RESET_PC.
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = pc4;
                    instr_d = imem_data_i;
                    pc4_d   = pc4;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (stall_i) begin
                    // Hold everything; a pending redirect is re-evaluated next cycle.
                end else if (take) begin
                    pc_d    = target;
                    instr_d = NOP_INSTR;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    pc_d    = pc4;
                    instr_d = imem_data_i;
                    pc4_d   = pc4;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr_o    = pc_q;
    assign ifid_instr_o   = instr_q;
    assign ifid_pc4_o     = pc4_q;
    assign ifid_valid_o   = valid_q;
    assign op_o           = instr_q[31:26];
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

    localparam int          TB_CNT_W = 8;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int unsigned CNT_MAX = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] I_J40  = 32'h0800_0040;
    localparam logic [31:0] I_J0   = 32'h0800_0000;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i, stall_i, branch_i, jump_i, eq_i;
    logic [31:0]         imem_data_i;
    logic [31:0]         imem_addr_o, ifid_instr_o, ifid_pc4_o;
    logic                ifid_valid_o;
    logic [5:0]          op_o;
    logic [TB_CNT_W-1:0] redirect_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid;
    int unsigned m_cnt;

    fetch_unit #(.RESET_PC(TB_RESET_PC), .CNT_W(TB_CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .jump_i         (jump_i),
        .eq_i           (eq_i),
        .imem_data_i    (imem_data_i),
        .imem_addr_o    (imem_addr_o),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc4_o     (ifid_pc4_o),
        .ifid_valid_o   (ifid_valid_o),
        .op_o           (op_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = TB_RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_fetch(input logic [31:0] d);
        m_instr = d;
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc4;
        m_valid = 1;
    endtask

    task automatic model_step(input bit st, input bit stl, input bit br, input bit jp,
                              input bit e, input logic [31:0] d);
        int          imm;
        logic [31:0] tgt;
        if (!m_run) begin
            if (st) begin
                m_run = 1;
                model_fetch(d);
            end
        end else if (!stl) begin
            if (m_valid && (jp || (br && e))) begin
                imm = int'($signed(m_instr[15:0]));
                if (jp) tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
                else    tgt = m_pc4 + 32'(imm * 4);
                m_pc    = tgt;
                m_instr = 32'h0;
                m_pc4   = 32'h0;
                m_valid = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                model_fetch(d);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr_o, m_pc);
        check({tag, ".instr"}, ifid_instr_o, m_instr);
        check({tag, ".pc4"},   ifid_pc4_o, m_pc4);
        check({tag, ".valid"}, 32'(ifid_valid_o), 32'(m_valid));
        check({tag, ".op"},    32'(op_o), m_instr >> 26);
        check({tag, ".cnt"},   32'(redirect_cnt_o), m_cnt);
    endtask

    // Drive one cycle of inputs at the negedge, advance the model, check at the next negedge.
    task automatic cycle(input string tag, input bit st, input bit stl, input bit br,
                         input bit jp, input bit e, input logic [31:0] d);
        start_i = st; stall_i = stl; branch_i = br; jump_i = jp; eq_i = e; imem_data_i = d;
        model_step(st, stl, br, jp, e, d);
        @(negedge clk_i);
        check_all(tag);
    endtask

    initial begin
        logic [31:0] d;
        bit st, stl;
        rst_i = 1'b0; start_i = 0; stall_i = 0; branch_i = 0; jump_i = 0; eq_i = 0;
        imem_data_i = 32'h0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all("reset");
        rst_i = 1'b1;

        // Idle: nothing moves without start
        cycle("idle", 0, 0, 1, 1, 1, I_ADDI);
        check("idle_pc", imem_addr_o, TB_RESET_PC);

        cycle("start", 1, 0, 0, 0, 0, I_ADDI);
        check("start_addr", imem_addr_o, 32'd4);
        check("start_instr", ifid_instr_o, I_ADDI);
        check("start_op", 32'(op_o), 32'h08);

        // Taken beq: pc4 0x10, imm -2 -> 0x08
        cycle("f8", 0, 0, 0, 0, 0, I_NOP);
        cycle("fc", 0, 0, 0, 0, 0, I_NOP);
        cycle("fbeq", 0, 0, 0, 0, 0, I_BEQ);
        check("beq_pc4", ifid_pc4_o, 32'h10);
        cycle("beq_t", 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        check("beq_t_pc", imem_addr_o, 32'h08);
        check("beq_t_valid", 32'(ifid_valid_o), 32'd0);
        check("beq_t_cnt", 32'(redirect_cnt_o), 32'd1);

        // Not-taken beq
        cycle("fbeq2", 0, 0, 0, 0, 0, I_BEQ);
        cycle("beq_nt", 0, 0, 1, 0, 0, I_NOP);
        check("beq_nt_pc", imem_addr_o, 32'h10);
        check("beq_nt_valid", 32'(ifid_valid_o), 32'd1);
        check("beq_nt_cnt", 32'(redirect_cnt_o), 32'd1);

        // Jump, with branch also raised: jump wins
        cycle("fj", 0, 0, 0, 0, 0, I_J40);
        cycle("jmp", 0, 0, 1, 1, 1, 32'h1234_5678);
        check("jmp_pc", imem_addr_o, 32'h100);
        check("jmp_valid", 32'(ifid_valid_o), 32'd0);

        // Stall for two cycles with a pending taken branch
        cycle("fbeq3", 0, 0, 0, 0, 0, I_BEQ);
        cycle("stall1", 0, 1, 1, 0, 1, 32'h1111_1111);
        cycle("stall2", 0, 1, 1, 0, 1, 32'h2222_2222);
        check("stall_pc", imem_addr_o, 32'h104);
        check("stall_cnt", 32'(redirect_cnt_o), 32'd2);
        cycle("unstall", 0, 0, 1, 0, 1, 32'h3333_3333);
        check("unstall_pc", imem_addr_o, 32'hFC);
        check("unstall_cnt", 32'(redirect_cnt_o), 32'd3);

        // Branch back from address 0 lands on 0xFFFF_FFFC; next fetch wraps to 0
        cycle("fj0", 0, 0, 0, 0, 0, I_J0);
        cycle("j0", 0, 0, 0, 1, 0, I_NOP);
        cycle("fbeq0", 0, 0, 0, 0, 0, I_BEQ);
        cycle("bwrap", 0, 0, 1, 0, 1, I_NOP);
        check("bwrap_pc", imem_addr_o, 32'hFFFF_FFFC);
        cycle("wrap", 0, 0, 0, 0, 0, I_ADDI);
        check("wrap_pc", imem_addr_o, 32'h0);
        check("wrap_pc4", ifid_pc4_o, 32'h0);

        // Saturate the redirect counter
        for (int i = 0; i < 300; i++) begin
            cycle("sat_f", 0, 0, 0, 0, 0, I_J0);
            cycle("sat_j", 0, 0, 0, 1, 0, I_NOP);
        end
        check("sat_cnt", 32'(redirect_cnt_o), CNT_MAX);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            d   = $urandom;
            st  = ($urandom_range(3) == 0);
            stl = ($urandom_range(3) == 0);
            cycle("rand", st, stl, ($urandom_range(2) == 0), ($urandom_range(5) == 0),
                  $urandom_range(1) == 1, d);
        end

        // Asynchronous reset between clock edges
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst_idle", 0, 0, 1, 1, 1, I_BEQ);
        check("post_rst_pc", imem_addr_o, TB_RESET_PC);
        cycle("restart", 1, 0, 0, 0, 0, I_ADDI);
        for (int i = 0; i < 200; i++) begin
            cycle("rand2", 0, ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(5) == 0), $urandom_range(1) == 1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
